seq_load_txn_gen: RTL and testbench

SEQ_LOAD_TXN_GEN -- requirements
Module: seq_load_txn_gen

---
 rtl/vlsu_pkg.sv | 42 ++++
 rtl/QueueFlow.sv | 60 ++++++
 rtl/seq_load_txn_gen.sv | 187 ++++++++++++++++++
 tb/tb_seq_load_txn_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load unit: FSM states,
// the global meta record, the per-beat transaction control record and
// the FIFO entry pushed on every AR handshake.
package vlsu_pkg;

    // An AXI burst may not cross a 4 KiB page and may not exceed 256 beats.
    localparam int unsigned PageBytes     = 4096;
    localparam int unsigned MaxBurstBeats = 256;

    // Address carried in txn records; wide enough for the widest AR address.
    localparam int unsigned TxnAddrWidth = 64;
    // Last-beat nibble count; holds busNibbles for buses up to 1024 bits.
    localparam int unsigned LbnWidth     = 9;

    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic [63:0] vstart;
        logic [1:0]  sew;
    } meta_glb_t;

    typedef struct packed {
        logic [TxnAddrWidth-1:0] addr;
        logic                    is_head;
        logic [7:0]              rmn_beat;
        logic [LbnWidth-1:0]     lb_n;
        logic                    is_final_txn;
    } txn_ctrl_t;

    typedef struct packed {
        logic [TxnAddrWidth-1:0] addr;
        logic [7:0]              nr_beat;
        logic [LbnWidth-1:0]     lb_n;
        logic                    is_final_txn;
    } txn_entry_t;

endpackage

// File: rtl/QueueFlow.sv
// Small synchronous FIFO with valid/ready on both sides. A push is
// refused while full, even if a pop happens in the same cycle.
module QueueFlow #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_valid_i,
    input  T     push_data_i,
    output logic push_ready_o,
    output logic pop_valid_o,
    output T     pop_data_o,
    input  logic pop_ready_i
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);

    T                    mem_q [DEPTH];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                push_fire;
    logic                pop_fire;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign push_ready_o = (cnt_q != CntWidth'(DEPTH));
    assign pop_valid_o  = (cnt_q != '0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop_fire     = pop_valid_o && pop_ready_i;

    // Read/write pointers and occupancy count.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_fire)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_fire && !pop_fire)      cnt_q <= cnt_q + CntWidth'(1);
            else if (!push_fire && pop_fire) cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, since occupancy (which is reset) gates pop_valid_o.
    always_ff @(posedge clk_i) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/seq_load_txn_gen.sv
// Unit-stride load transaction generator: splits one vector load request
// into AXI INCR bursts (page- and 256-beat-limited), emits one meta record
// per request, and replays each issued burst as per-beat txn records.
module seq_load_txn_gen
    import vlsu_pkg::*;
#(
    parameter int unsigned AxiDataWidth  = 128,
    parameter int unsigned AxiAddrWidth  = 64,
    parameter int unsigned NrOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [63:0]             req_vstart_i,
    input  logic [63:0]             req_vl_i,
    input  logic [1:0]              req_sew_i,
    output logic                    req_ready_o,
    output logic                    ar_valid_o,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    input  logic                    ar_ready_i,
    output logic                    meta_glb_valid_o,
    output meta_glb_t               meta_glb_o,
    input  logic                    meta_glb_ready_i,
    output logic                    txn_ctrl_valid_o,
    output txn_ctrl_t               txn_ctrl_o,
    input  logic                    txn_ctrl_ready_i,
    output logic                    busy_o
);

    localparam int unsigned BusBytes   = AxiDataWidth / 8;
    localparam int unsigned BusNibbles = AxiDataWidth / 4;
    localparam int unsigned SizeLog2   = $clog2(BusBytes);
    localparam int unsigned PageOffW   = $clog2(PageBytes);

    typedef logic [AxiAddrWidth-1:0] addr_t;

    state_e              state_q, state_d;
    addr_t               cur_q, end_q;
    meta_glb_t           meta_q;
    logic                meta_done_q, ar_done_q;
    logic [7:0]          beat_cnt_q;

    logic                req_nonempty, req_accept;
    addr_t               start_addr, end_addr;
    addr_t               cur_aligned, rem_bytes, next_cur, end_m1;
    logic [PageOffW-1:0] page_off;
    logic [31:0]         page_beats;
    logic [AxiAddrWidth:0] need_beats;
    logic [8:0]          beats;
    logic                ar_is_final, ar_fire, meta_fire;
    logic [LbnWidth-1:0] last_bytes, ar_lb_n;
    logic                fifo_push_ready;
    txn_entry_t          push_entry, head_entry;
    logic [7:0]          txn_rmn;
    logic                txn_fire, txn_pop;

    // Request window in bytes; both ends wrap modulo the address width.
    assign req_nonempty = (req_vstart_i < req_vl_i);
    assign start_addr   = req_addr_i + addr_t'(req_vstart_i << req_sew_i);
    assign end_addr     = req_addr_i + addr_t'(req_vl_i << req_sew_i);
    assign req_accept   = req_ready_o && req_valid_i && req_nonempty;

    // Burst sizing from the bus-aligned current address.
    assign cur_aligned = cur_q & ~addr_t'(BusBytes - 1);
    assign page_off    = cur_aligned[PageOffW-1:0];
    assign page_beats  = (PageBytes - 32'(page_off)) >> SizeLog2;
    assign rem_bytes   = end_q - cur_aligned;
    assign need_beats  = ({1'b0, rem_bytes} + (AxiAddrWidth + 1)'(BusBytes - 1)) >> SizeLog2;

    // Burst length is the tightest of the three limits.
    always_comb begin
        beats = 9'(MaxBurstBeats);
        if (page_beats < 32'(beats))                   beats = 9'(page_beats);
        if (need_beats < (AxiAddrWidth + 1)'(beats))   beats = 9'(need_beats);
    end

    assign next_cur    = cur_aligned + (addr_t'(beats) << SizeLog2);
    assign ar_is_final = (next_cur >= end_q);
    assign end_m1      = end_q - addr_t'(1);
    assign last_bytes  = LbnWidth'(end_m1 & addr_t'(BusBytes - 1)) + LbnWidth'(1);
    assign ar_lb_n     = ar_is_final ? (last_bytes << 1) : LbnWidth'(BusNibbles);

    // AR fields depend only on cur_q/end_q, so they hold while stalled.
    assign ar_addr_o  = cur_q;
    assign ar_len_o   = 8'(beats - 9'd1);
    assign ar_size_o  = 3'(SizeLog2);
    assign ar_burst_o = BurstIncr;
    assign ar_fire    = ar_valid_o && ar_ready_i;
    assign meta_fire  = meta_glb_valid_o && meta_glb_ready_i;
    assign meta_glb_o = meta_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; ISSUE ends once both the final AR
    // and the meta record have gone out, whichever comes last.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        meta_glb_valid_o = 1'b0;
        ar_valid_o       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && req_nonempty) state_d = ISSUE;
            end
            ISSUE: begin
                meta_glb_valid_o = !meta_done_q;
                ar_valid_o       = !ar_done_q && fifo_push_ready;
                if ((ar_done_q || (ar_valid_o && ar_ready_i && ar_is_final)) &&
                    (meta_done_q || (meta_glb_valid_o && meta_glb_ready_i)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-request registers: address walk, window end, meta and done flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q       <= '0;
            end_q       <= '0;
            meta_q      <= '0;
            meta_done_q <= 1'b0;
            ar_done_q   <= 1'b0;
        end else if (req_accept) begin
            cur_q       <= start_addr;
            end_q       <= end_addr;
            meta_q      <= '{vstart: req_vstart_i, sew: req_sew_i};
            meta_done_q <= 1'b0;
            ar_done_q   <= 1'b0;
        end else begin
            if (ar_fire) begin
                cur_q <= next_cur;
                if (ar_is_final) ar_done_q <= 1'b1;
            end
            if (meta_fire) meta_done_q <= 1'b1;
        end
    end

    assign push_entry = '{addr:         TxnAddrWidth'(cur_q),
                          nr_beat:      ar_len_o,
                          lb_n:         ar_lb_n,
                          is_final_txn: ar_is_final};

    QueueFlow #(
        .T     (txn_entry_t),
        .DEPTH (NrOutstanding)
    ) i_txn_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (ar_fire),
        .push_data_i  (push_entry),
        .push_ready_o (fifo_push_ready),
        .pop_valid_o  (txn_ctrl_valid_o),
        .pop_data_o   (head_entry),
        .pop_ready_i  (txn_pop)
    );

    // Per-beat view of the FIFO head; the entry leaves on its last beat.
    assign txn_rmn    = head_entry.nr_beat - beat_cnt_q;
    assign txn_ctrl_o = '{addr:         head_entry.addr,
                          is_head:      (beat_cnt_q == 8'd0),
                          rmn_beat:     txn_rmn,
                          lb_n:         head_entry.lb_n,
                          is_final_txn: head_entry.is_final_txn};
    assign txn_fire   = txn_ctrl_valid_o && txn_ctrl_ready_i;
    assign txn_pop    = txn_fire && (txn_rmn == 8'd0);
    assign busy_o     = (state_q != IDLE) || txn_ctrl_valid_o;

    // Beat counter within the head burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       beat_cnt_q <= 8'd0;
        else if (txn_pop)  beat_cnt_q <= 8'd0;
        else if (txn_fire) beat_cnt_q <= beat_cnt_q + 8'd1;
    end

endmodule

// File: tb/tb_seq_load_txn_gen.sv
// Bench for seq_load_txn_gen (128-bit bus, two outstanding bursts):
// directed corner cases plus random requests under random back-pressure,
// compared against a byte-arithmetic model of the burst split.
module tb_seq_load_txn_gen;
    import vlsu_pkg::*;

    localparam longint unsigned BUS_BYTES = 16;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_rec_t;

    logic        clk_i, rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [63:0] req_addr_i, req_vstart_i, req_vl_i;
    logic [1:0]  req_sew_i;
    logic        ar_valid_o, ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        meta_glb_valid_o, meta_glb_ready_i;
    meta_glb_t   meta_glb_o;
    logic        txn_ctrl_valid_o, txn_ctrl_ready_i;
    txn_ctrl_t   txn_ctrl_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    // Ready behaviour per channel: 0 = low, 1 = high, 2 = random.
    int ar_mode = 1, meta_mode = 1, txn_mode = 1;

    ar_rec_t   ar_log[$],   ar_exp[$];
    txn_ctrl_t txn_log[$],  txn_exp[$];
    meta_glb_t meta_log[$], meta_exp[$];

    seq_load_txn_gen #(
        .AxiDataWidth  (128),
        .AxiAddrWidth  (64),
        .NrOutstanding (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_addr_i       (req_addr_i),
        .req_vstart_i     (req_vstart_i),
        .req_vl_i         (req_vl_i),
        .req_sew_i        (req_sew_i),
        .req_ready_o      (req_ready_o),
        .ar_valid_o       (ar_valid_o),
        .ar_addr_o        (ar_addr_o),
        .ar_len_o         (ar_len_o),
        .ar_size_o        (ar_size_o),
        .ar_burst_o       (ar_burst_o),
        .ar_ready_i       (ar_ready_i),
        .meta_glb_valid_o (meta_glb_valid_o),
        .meta_glb_o       (meta_glb_o),
        .meta_glb_ready_i (meta_glb_ready_i),
        .txn_ctrl_valid_o (txn_ctrl_valid_o),
        .txn_ctrl_o       (txn_ctrl_o),
        .txn_ctrl_ready_i (txn_ctrl_ready_i),
        .busy_o           (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference split: walk the byte window, cutting at 4 KiB pages, at
    // 256 beats and at the window end; every burst expands into its beats.
    task automatic model_req(input longint unsigned addr, input longint unsigned vstart,
                             input longint unsigned vl, input int sew);
        longint unsigned s, e, cur, al, page_beats, need, beats, nxt, lbn;
        logic fin;
        if (vstart >= vl) return;
        meta_exp.push_back('{vstart: vstart, sew: 2'(sew)});
        s   = addr + (vstart << sew);
        e   = addr + (vl << sew);
        cur = s;
        while (cur < e) begin
            al         = cur - (cur % BUS_BYTES);
            page_beats = (4096 - (al % 4096)) / BUS_BYTES;
            need       = (e - al + BUS_BYTES - 1) / BUS_BYTES;
            beats      = 256;
            if (page_beats < beats) beats = page_beats;
            if (need < beats)       beats = need;
            nxt = al + beats * BUS_BYTES;
            fin = (nxt >= e);
            lbn = fin ? (((e - 1) % BUS_BYTES) + 1) * 2 : BUS_BYTES * 2;
            ar_exp.push_back('{addr: cur, len: 8'(beats - 1), size: 3'd4, burst: 2'b01});
            for (longint unsigned b = 0; b < beats; b++)
                txn_exp.push_back('{addr: cur, is_head: (b == 0), rmn_beat: 8'(beats - 1 - b),
                                    lb_n: 9'(lbn), is_final_txn: fin});
            cur = nxt;
        end
    endtask

    // One clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        ar_ready_i       = (ar_mode   == 2) ? 1'($urandom_range(0, 1)) : 1'(ar_mode);
        meta_glb_ready_i = (meta_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(meta_mode);
        txn_ctrl_ready_i = (txn_mode  == 2) ? 1'($urandom_range(0, 1)) : 1'(txn_mode);
    endtask

    task automatic issue_req(input longint unsigned addr, input longint unsigned vstart,
                             input longint unsigned vl, input int sew);
        int n = 0;
        model_req(addr, vstart, vl, sew);
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_vstart_i = vstart;
        req_vl_i     = vl;
        req_sew_i    = 2'(sew);
        while (!req_ready_o && n < 2000) begin
            step();
            n++;
        end
        check("req_ready before request", 128'(req_ready_o), 128'(1));
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            step();
            n++;
        end
        check({tag, " idle after drain"}, 128'(busy_o), 128'(0));
    endtask

    task automatic clear_logs();
        ar_log.delete();  ar_exp.delete();
        txn_log.delete(); txn_exp.delete();
        meta_log.delete(); meta_exp.delete();
    endtask

    task automatic compare_logs(input string tag);
        check({tag, " ar count"},   128'(ar_log.size()),   128'(ar_exp.size()));
        check({tag, " txn count"},  128'(txn_log.size()),  128'(txn_exp.size()));
        check({tag, " meta count"}, 128'(meta_log.size()), 128'(meta_exp.size()));
        foreach (ar_exp[i])
            if (i < ar_log.size()) check($sformatf("%s ar[%0d]", tag, i), 128'(ar_log[i]), 128'(ar_exp[i]));
        foreach (txn_exp[i])
            if (i < txn_log.size()) check($sformatf("%s txn[%0d]", tag, i), 128'(txn_log[i]), 128'(txn_exp[i]));
        foreach (meta_exp[i])
            if (i < meta_log.size()) check($sformatf("%s meta[%0d]", tag, i), 128'(meta_log[i]), 128'(meta_exp[i]));
        clear_logs();
    endtask

    // Handshake monitor and AR stability check, sampled on the falling edge.
    ar_rec_t prev_ar;
    logic    prev_stall = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && ar_valid_o)
                check("ar stable under stall",
                      128'(ar_rec_t'{ar_addr_o, ar_len_o, ar_size_o, ar_burst_o}), 128'(prev_ar));
            if (ar_valid_o && ar_ready_i)
                ar_log.push_back('{ar_addr_o, ar_len_o, ar_size_o, ar_burst_o});
            if (meta_glb_valid_o && meta_glb_ready_i) meta_log.push_back(meta_glb_o);
            if (txn_ctrl_valid_o && txn_ctrl_ready_i) txn_log.push_back(txn_ctrl_o);
            prev_stall <= ar_valid_o && !ar_ready_i;
            prev_ar    <= '{ar_addr_o, ar_len_o, ar_size_o, ar_burst_o};
        end
    end

    initial begin
        int n;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_vstart_i = '0; req_vl_i = '0; req_sew_i = '0;
        ar_ready_i = 1'b1; meta_glb_ready_i = 1'b1; txn_ctrl_ready_i = 1'b1;

        // Reset state, during and just after reset.
        #2;
        check("rst req_ready",  128'(req_ready_o),      128'(1));
        check("rst ar_valid",   128'(ar_valid_o),       128'(0));
        check("rst meta_valid", 128'(meta_glb_valid_o), 128'(0));
        check("rst txn_valid",  128'(txn_ctrl_valid_o), 128'(0));
        check("rst busy",       128'(busy_o),           128'(0));
        step(); step();
        rst_ni = 1'b1;
        step();
        check("post-rst req_ready", 128'(req_ready_o), 128'(1));
        check("post-rst busy",      128'(busy_o),      128'(0));

        // Single unaligned burst; meta held back to show ISSUE waits for it.
        meta_mode = 0;
        issue_req(64'h1004, 0, 8, 2);
        check("meta valid after entry", 128'(meta_glb_valid_o), 128'(1));
        check("meta payload", 128'(meta_glb_o), 128'(meta_glb_t'{vstart: 64'd0, sew: 2'd2}));
        step(); step(); step();
        check("busy while meta pending", 128'(busy_o),      128'(1));
        check("no req_ready in ISSUE",   128'(req_ready_o), 128'(0));
        meta_mode = 1;
        drain("single", 200);
        if (ar_log.size() > 0)
            check("single ar", 128'(ar_log[0]), 128'(ar_rec_t'{64'h1004, 8'd2, 3'd4, 2'b01}));
        if (txn_log.size() == 3) begin
            check("single beat0 head", 128'({txn_log[0].is_head, txn_log[0].rmn_beat}), 128'({1'b1, 8'd2}));
            check("single beat1 head", 128'({txn_log[1].is_head, txn_log[1].rmn_beat}), 128'({1'b0, 8'd1}));
            check("single beat2 last", 128'({txn_log[2].is_head, txn_log[2].rmn_beat,
                                             txn_log[2].lb_n, txn_log[2].is_final_txn}),
                                       128'({1'b0, 8'd0, 9'd8, 1'b1}));
        end
        compare_logs("single");

        // Page crossing: two one-beat bursts, both full-width last beats.
        issue_req(64'h0FF0, 0, 8, 2);
        drain("page", 200);
        if (ar_log.size() == 2) begin
            check("page ar1 addr", 128'(ar_log[1].addr), 128'(64'h1000));
            check("page lbn0",     128'(txn_log[0].lb_n), 128'(9'd32));
        end
        compare_logs("page");

        // Two maximal bursts: 256 beats each.
        issue_req(64'h0, 0, 1024, 3);
        drain("max", 2000);
        check("max beats", 128'(txn_log.size()), 128'(512));
        compare_logs("max");

        // Empty request is accepted and dropped.
        issue_req(64'h100, 5, 5, 2);
        check("drop req_ready next", 128'(req_ready_o), 128'(1));
        check("drop busy",           128'(busy_o),      128'(0));
        repeat (5) step();
        compare_logs("drop");

        // New request while earlier beats are still queued.
        txn_mode = 0;
        issue_req(64'h1004, 0, 8, 2);
        n = 0;
        while (!req_ready_o && n < 100) begin step(); n++; end
        check("overlap back to idle", 128'(req_ready_o),      128'(1));
        check("overlap entry pending", 128'(txn_ctrl_valid_o), 128'(1));
        issue_req(64'h2000, 2, 6, 3);
        txn_mode = 2;
        drain("overlap", 500);
        compare_logs("overlap");

        // FIFO full: four bursts, only two may issue until a pop.
        txn_mode = 0;
        issue_req(64'h0FF0, 0, 64'h2020, 0);
        repeat (20) step();
        check("full ar count", 128'(ar_log.size()), 128'(2));
        check("full ar_valid", 128'(ar_valid_o),    128'(0));
        check("full busy",     128'(busy_o),        128'(1));
        txn_mode = 1;
        n = 0;
        while (!ar_valid_o && n < 20) begin step(); n++; end
        check("full ar after pop",   128'(ar_valid_o),           128'(1));
        check("full pop before ar",  128'(txn_log.size() >= 1),  128'(1));
        drain("full", 3000);
        compare_logs("full");

        // Random requests under random back-pressure.
        ar_mode = 2; meta_mode = 2; txn_mode = 2;
        for (int i = 0; i < 8; i++) begin
            longint unsigned a, vs, vl;
            int sw;
            a  = longint'($urandom_range(0, 32'h7FFF));
            sw = int'($urandom_range(0, 3));
            vl = longint'($urandom_range(1, 200));
            vs = longint'($urandom_range(0, 32'(vl - 1)));
            issue_req(a, vs, vl, sw);
            drain($sformatf("rand%0d", i), 4000);
            compare_logs($sformatf("rand%0d", i));
        end

        // Reset in the middle of a long request.
        issue_req(64'h0, 0, 1024, 3);
        repeat (40) step();
        rst_ni = 1'b0;
        #1;
        check("midrst ar_valid",   128'(ar_valid_o),       128'(0));
        check("midrst meta_valid", 128'(meta_glb_valid_o), 128'(0));
        check("midrst txn_valid",  128'(txn_ctrl_valid_o), 128'(0));
        check("midrst req_ready",  128'(req_ready_o),      128'(1));
        step();
        rst_ni = 1'b1;
        step();
        check("midrst fifo empty", 128'(txn_ctrl_valid_o), 128'(0));
        check("midrst busy",       128'(busy_o),           128'(0));
        clear_logs();

        // Recovery after reset.
        ar_mode = 1; meta_mode = 1; txn_mode = 1;
        issue_req(64'h0FF0, 0, 8, 2);
        drain("recover", 200);
        compare_logs("recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
